// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Multi-cycle sequencer for a tiny register-file ALU. Accepts
//               LDI / MOV / ADD / SUB commands, reads operands through an
//               external combinational register-file port, performs the
//               operation and writes the result back with an active-low
//               write enable.
// Ports       : ck, res                       - clock, async active-high reset
//               cmd_valid/cmd_ready           - command handshake
//               cmd_op/dst/srca/srcb/imm      - command fields
//               rf_q, rf_rsel                 - register-file read port
//               rf_wsel, rf_d, rf_we          - register-file write port
//               done                          - one-cycle completion pulse
//               result, carry                 - outcome of last command
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int DW = 16
) (
    input  logic          ck,
    input  logic          res,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [1:0]    cmd_dst,
    input  logic [1:0]    cmd_srca,
    input  logic [1:0]    cmd_srcb,
    input  logic [DW-1:0] cmd_imm,
    input  logic [DW-1:0] rf_q,
    output logic [1:0]    rf_rsel,
    output logic [1:0]    rf_wsel,
    output logic [DW-1:0] rf_d,
    output logic          rf_we,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          carry
);

    localparam logic [1:0] c_op_ldi = 2'd0;
    localparam logic [1:0] c_op_mov = 2'd1;
    localparam logic [1:0] c_op_add = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RDA  = 3'd1,
        S_RDB  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        r_state;
    logic [1:0]    r_op;
    logic [1:0]    r_dst;
    logic [1:0]    r_srcb;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;

    // Operand B comes straight from the read port while it is being read
    // (RDB), so the write data can be registered on entry to WR; in WR it
    // comes from the captured copy so the same adder yields the carry.
    logic [DW-1:0] w_opb;
    logic [DW:0]   w_sum;
    logic [DW:0]   w_diff;

    assign w_opb  = (r_state == S_RDB) ? rf_q : r_b;
    assign w_sum  = {1'b0, r_a} + {1'b0, w_opb};
    // Bit DW of the extended difference is the unsigned borrow (A < B).
    assign w_diff = {1'b0, r_a} - {1'b0, w_opb};

    always_ff @(posedge ck or posedge res) begin
        if (res) begin
            r_state   <= S_IDLE;
            r_op      <= 2'd0;
            r_dst     <= 2'd0;
            r_srcb    <= 2'd0;
            r_a       <= '0;
            r_b       <= '0;
            cmd_ready <= 1'b1;
            rf_rsel   <= 2'd0;
            rf_wsel   <= 2'd0;
            rf_d      <= '0;
            rf_we     <= 1'b1;
            done      <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (cmd_valid) begin
                        r_op      <= cmd_op;
                        r_dst     <= cmd_dst;
                        r_srcb    <= cmd_srcb;
                        cmd_ready <= 1'b0;
                        if (cmd_op == c_op_ldi) begin
                            // The immediate only matters for LDI, which goes
                            // straight to WR, so it is latched directly into
                            // the write-data register.
                            r_state <= S_WR;
                            rf_we   <= 1'b0;
                            rf_wsel <= cmd_dst;
                            rf_d    <= cmd_imm;
                        end else begin
                            // Source A is latched into the read select itself.
                            r_state <= S_RDA;
                            rf_rsel <= cmd_srca;
                        end
                    end else begin
                        r_state   <= S_IDLE;
                        cmd_ready <= 1'b1;
                    end
                end
                S_RDA: begin
                    r_a <= rf_q;
                    if (r_op == c_op_mov) begin
                        r_state <= S_WR;
                        rf_rsel <= 2'd0;
                        rf_we   <= 1'b0;
                        rf_wsel <= r_dst;
                        rf_d    <= rf_q;
                    end else begin
                        r_state <= S_RDB;
                        rf_rsel <= r_srcb;
                    end
                end
                S_RDB: begin
                    r_b     <= rf_q;
                    r_state <= S_WR;
                    rf_rsel <= 2'd0;
                    rf_we   <= 1'b0;
                    rf_wsel <= r_dst;
                    rf_d    <= (r_op == c_op_add) ? w_sum[DW-1:0] : w_diff[DW-1:0];
                end
                S_WR: begin
                    r_state   <= S_DONE;
                    result    <= rf_d;
                    // r_a/r_b hold both operands here, so w_sum/w_diff give carry.
                    case (r_op)
                        c_op_add: carry <= w_sum[DW];
                        2'd3:     carry <= w_diff[DW];
                        default:  carry <= 1'b0;
                    endcase
                    rf_we     <= 1'b1;
                    rf_wsel   <= 2'd0;
                    rf_d      <= '0;
                    done      <= 1'b1;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    r_state   <= S_IDLE;
                    cmd_ready <= 1'b1;
                    rf_rsel   <= 2'd0;
                    rf_wsel   <= 2'd0;
                    rf_d      <= '0;
                    rf_we     <= 1'b1;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed self-checking bench for alu_seq with a 4-entry
//               register-file model attached to the read/write ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    logic        ck;
    logic        res;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_dst;
    logic [1:0]  cmd_srca;
    logic [1:0]  cmd_srcb;
    logic [15:0] cmd_imm;
    logic [15:0] rf_q;
    logic [1:0]  rf_rsel;
    logic [1:0]  rf_wsel;
    logic [15:0] rf_d;
    logic        rf_we;
    logic        done;
    logic [15:0] result;
    logic        carry;

    int chk = 0;
    int err = 0;

    // Register-file model; preload port lets the bench seed values.
    logic [15:0] rf [4];
    logic        pl_en;
    logic [1:0]  pl_idx;
    logic [15:0] pl_val;

    always @(posedge ck) begin
        if (!rf_we) rf[rf_wsel] <= rf_d;
        else if (pl_en) rf[pl_idx] <= pl_val;
    end
    assign rf_q = rf[rf_rsel];

    alu_seq #(.DW(16)) dut (
        .ck        (ck),
        .res       (res),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dst   (cmd_dst),
        .cmd_srca  (cmd_srca),
        .cmd_srcb  (cmd_srcb),
        .cmd_imm   (cmd_imm),
        .rf_q      (rf_q),
        .rf_rsel   (rf_rsel),
        .rf_wsel   (rf_wsel),
        .rf_d      (rf_d),
        .rf_we     (rf_we),
        .done      (done),
        .result    (result),
        .carry     (carry)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic preload(input logic [1:0] idx, input logic [15:0] val);
        pl_idx = idx;
        pl_val = val;
        pl_en  = 1'b1;
        @(posedge ck);
        @(negedge ck);
        pl_en  = 1'b0;
    endtask

    // Presents one command for a single cycle starting at a negedge in IDLE;
    // returns at the negedge after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [1:0] dst,
                         input logic [1:0] sa, input logic [1:0] sb,
                         input logic [15:0] imm);
        cmd_op    = op;
        cmd_dst   = dst;
        cmd_srca  = sa;
        cmd_srcb  = sb;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        @(posedge ck);
        @(negedge ck);
        cmd_valid = 1'b0;
    endtask

    // Observes the port activity until done; lat counts cycles since accept.
    task automatic wait_done(input int start, output int lat, output int nwr,
                             output logic [1:0] wsel, output logic [15:0] wd,
                             output int nrd, output logic [1:0] rs0,
                             output logic [1:0] rs1);
        lat = -1; nwr = 0; nrd = 0; wsel = 2'd0; wd = 16'h0; rs0 = 2'd0; rs1 = 2'd0;
        for (int n = start; n <= start + 20; n++) begin
            if (done === 1'b1) begin
                lat = n;
                return;
            end
            if (rf_we === 1'b0) begin
                nwr++;
                wsel = rf_wsel;
                wd   = rf_d;
            end else if (cmd_ready === 1'b0) begin
                if (nrd == 0) rs0 = rf_rsel;
                else          rs1 = rf_rsel;
                nrd++;
            end
            @(posedge ck);
            @(negedge ck);
        end
    endtask

    task automatic test_reset();
        @(negedge ck);
        chk++; if (cmd_ready !== 1'b1) begin err++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
        chk++; if (rf_we !== 1'b1) begin err++; $display("FAIL rst_we: got %b want 1", rf_we); end
        chk++; if (done !== 1'b0) begin err++; $display("FAIL rst_done: got %b want 0", done); end
        chk++; if ({rf_rsel, rf_wsel, rf_d} !== 20'h0) begin err++; $display("FAIL rst_rf: got %h want 0", {rf_rsel, rf_wsel, rf_d}); end
        chk++; if ({carry, result} !== 17'h0) begin err++; $display("FAIL rst_result: got %h want 0", {carry, result}); end
        res = 1'b0;
        @(posedge ck);
        @(negedge ck);
        chk++; if (cmd_ready !== 1'b1 || rf_we !== 1'b1 || done !== 1'b0) begin
            err++; $display("FAIL idle_after_rst: got ready=%b we=%b done=%b want 1 1 0", cmd_ready, rf_we, done);
        end
    endtask

    task automatic test_ldi();
        int lat, nwr, nrd;
        logic [1:0] ws, r0s, r1s;
        logic [15:0] wd;
        issue(2'd0, 2'd2, 2'd0, 2'd0, 16'h1234);
        wait_done(1, lat, nwr, ws, wd, nrd, r0s, r1s);
        chk++; if (lat !== 2) begin err++; $display("FAIL ldi_lat: got %0d want 2", lat); end
        chk++; if (nwr !== 1 || ws !== 2'd2 || wd !== 16'h1234) begin
            err++; $display("FAIL ldi_write: got n=%0d sel=%0d d=%h want 1 2 1234", nwr, ws, wd);
        end
        chk++; if (result !== 16'h1234 || carry !== 1'b0) begin err++; $display("FAIL ldi_result: got %h/%b want 1234/0", result, carry); end
        chk++; if (rf[2] !== 16'h1234) begin err++; $display("FAIL ldi_rf: got %h want 1234", rf[2]); end
        @(posedge ck);
        @(negedge ck);
        chk++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin err++; $display("FAIL ldi_pulse: got done=%b ready=%b want 0 1", done, cmd_ready); end
    endtask

    task automatic test_add_carry();
        int lat, nwr, nrd;
        logic [1:0] ws, r0s, r1s;
        logic [15:0] wd;
        preload(2'd0, 16'hFFFF);
        preload(2'd1, 16'h0001);
        preload(2'd3, 16'h5555);
        issue(2'd2, 2'd3, 2'd0, 2'd1, 16'h0);
        wait_done(1, lat, nwr, ws, wd, nrd, r0s, r1s);
        chk++; if (lat !== 4) begin err++; $display("FAIL add_lat: got %0d want 4", lat); end
        chk++; if (nrd !== 2 || r0s !== 2'd0 || r1s !== 2'd1) begin
            err++; $display("FAIL add_rsel: got n=%0d %0d,%0d want 2 0,1", nrd, r0s, r1s);
        end
        chk++; if (nwr !== 1 || ws !== 2'd3 || wd !== 16'h0000) begin
            err++; $display("FAIL add_write: got n=%0d sel=%0d d=%h want 1 3 0000", nwr, ws, wd);
        end
        chk++; if (result !== 16'h0000 || carry !== 1'b1) begin err++; $display("FAIL add_result: got %h/%b want 0000/1", result, carry); end
        chk++; if (rf[3] !== 16'h0000) begin err++; $display("FAIL add_rf: got %h want 0000", rf[3]); end
        @(posedge ck);
        @(negedge ck);
    endtask

    task automatic test_sub();
        int lat, nwr, nrd;
        logic [1:0] ws, r0s, r1s;
        logic [15:0] wd;
        preload(2'd0, 16'h0003);
        preload(2'd1, 16'h0005);
        issue(2'd3, 2'd0, 2'd0, 2'd1, 16'h0);
        wait_done(1, lat, nwr, ws, wd, nrd, r0s, r1s);
        chk++; if (lat !== 4) begin err++; $display("FAIL sub_lat: got %0d want 4", lat); end
        chk++; if (rf[0] !== 16'hFFFE || result !== 16'hFFFE || carry !== 1'b1) begin
            err++; $display("FAIL sub_borrow: got rf=%h res=%h c=%b want fffe fffe 1", rf[0], result, carry);
        end
        @(posedge ck);
        @(negedge ck);
        preload(2'd0, 16'h0003);
        // Swapped operands, with a stray command presented during RDA.
        issue(2'd3, 2'd2, 2'd1, 2'd0, 16'h0);
        cmd_op = 2'd0; cmd_dst = 2'd1; cmd_srca = 2'd3; cmd_srcb = 2'd3; cmd_imm = 16'hDEAD;
        cmd_valid = 1'b1;
        @(posedge ck);
        @(negedge ck);
        cmd_valid = 1'b0;
        wait_done(2, lat, nwr, ws, wd, nrd, r0s, r1s);
        chk++; if (lat !== 4) begin err++; $display("FAIL sub2_lat: got %0d want 4", lat); end
        chk++; if (rf[2] !== 16'h0002 || result !== 16'h0002 || carry !== 1'b0) begin
            err++; $display("FAIL sub_swap: got rf=%h res=%h c=%b want 0002 0002 0", rf[2], result, carry);
        end
        chk++; if (rf[1] !== 16'h0005 || nwr !== 1 || ws !== 2'd2) begin
            err++; $display("FAIL sub_ignore: got r1=%h n=%0d sel=%0d want 0005 1 2", rf[1], nwr, ws);
        end
        @(posedge ck);
        @(negedge ck);
    endtask

    task automatic test_alias_mov();
        int lat, nwr, nrd;
        logic [1:0] ws, r0s, r1s;
        logic [15:0] wd;
        preload(2'd1, 16'h4000);
        issue(2'd2, 2'd1, 2'd1, 2'd1, 16'h0);
        wait_done(1, lat, nwr, ws, wd, nrd, r0s, r1s);
        chk++; if (rf[1] !== 16'h8000 || carry !== 1'b0) begin
            err++; $display("FAIL alias_add: got r1=%h c=%b want 8000 0", rf[1], carry);
        end
        @(posedge ck);
        @(negedge ck);
        issue(2'd1, 2'd2, 2'd1, 2'd0, 16'h0);
        wait_done(1, lat, nwr, ws, wd, nrd, r0s, r1s);
        chk++; if (lat !== 3) begin err++; $display("FAIL mov_lat: got %0d want 3", lat); end
        chk++; if (nrd !== 1 || r0s !== 2'd1) begin err++; $display("FAIL mov_rsel: got n=%0d sel=%0d want 1 1", nrd, r0s); end
        chk++; if (rf[2] !== 16'h8000 || result !== 16'h8000 || carry !== 1'b0) begin
            err++; $display("FAIL mov_value: got rf=%h res=%h c=%b want 8000 8000 0", rf[2], result, carry);
        end
        @(posedge ck);
        @(negedge ck);
    endtask

    task automatic test_back_to_back();
        logic [0:10] exp_r;
        logic [0:10] exp_d;
        int k;
        int ndone;
        exp_r = 11'b10100100011;
        exp_d = 11'b00100100010;
        k = 0;
        ndone = 0;
        for (int i = 0; i < 11; i++) begin
            chk++; if (cmd_ready !== exp_r[i] || done !== exp_d[i]) begin
                err++; $display("FAIL b2b_cycle%0d: got ready=%b done=%b want %b %b", i, cmd_ready, done, exp_r[i], exp_d[i]);
            end
            if (done === 1'b1) ndone++;
            if (exp_r[i]) begin
                case (k)
                    0: begin cmd_op = 2'd0; cmd_dst = 2'd0; cmd_srca = 2'd0; cmd_srcb = 2'd0; cmd_imm = 16'h0007; cmd_valid = 1'b1; end
                    1: begin cmd_op = 2'd1; cmd_dst = 2'd1; cmd_srca = 2'd0; cmd_srcb = 2'd0; cmd_imm = 16'h0; cmd_valid = 1'b1; end
                    2: begin cmd_op = 2'd2; cmd_dst = 2'd2; cmd_srca = 2'd0; cmd_srcb = 2'd1; cmd_imm = 16'h0; cmd_valid = 1'b1; end
                    default: cmd_valid = 1'b0;
                endcase
                k++;
            end
            @(posedge ck);
            @(negedge ck);
        end
        cmd_valid = 1'b0;
        chk++; if (ndone !== 3) begin err++; $display("FAIL b2b_done_count: got %0d want 3", ndone); end
        chk++; if (rf[2] !== 16'h000E || result !== 16'h000E) begin
            err++; $display("FAIL b2b_value: got rf=%h res=%h want 000e 000e", rf[2], result);
        end
    endtask

    task automatic test_reset_in_wr();
        int lat, nwr, nrd;
        logic [1:0] ws, r0s, r1s;
        logic [15:0] wd;
        preload(2'd3, 16'h1111);
        issue(2'd0, 2'd3, 2'd0, 2'd0, 16'hBEEF);
        chk++; if (rf_we !== 1'b0) begin err++; $display("FAIL rwr_in_wr: got we=%b want 0", rf_we); end
        #2 res = 1'b1;
        #1;
        chk++; if (rf_we !== 1'b1 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            err++; $display("FAIL rwr_async: got we=%b done=%b ready=%b want 1 0 1", rf_we, done, cmd_ready);
        end
        chk++; if ({rf_rsel, rf_wsel, rf_d} !== 20'h0 || {carry, result} !== 17'h0) begin
            err++; $display("FAIL rwr_outputs: got rf=%h res=%h want 0 0", {rf_rsel, rf_wsel, rf_d}, {carry, result});
        end
        @(posedge ck);
        @(negedge ck);
        chk++; if (rf[3] !== 16'h1111 || done !== 1'b0) begin
            err++; $display("FAIL rwr_nowrite: got r3=%h done=%b want 1111 0", rf[3], done);
        end
        res = 1'b0;
        cmd_op = 2'd0; cmd_dst = 2'd3; cmd_srca = 2'd0; cmd_srcb = 2'd0; cmd_imm = 16'h00A5;
        cmd_valid = 1'b1;
        @(posedge ck);
        @(negedge ck);
        cmd_valid = 1'b0;
        chk++; if (rf_we !== 1'b0 || rf_wsel !== 2'd3) begin
            err++; $display("FAIL rwr_first_accept: got we=%b sel=%0d want 0 3", rf_we, rf_wsel);
        end
        wait_done(1, lat, nwr, ws, wd, nrd, r0s, r1s);
        chk++; if (lat !== 2 || rf[3] !== 16'h00A5) begin
            err++; $display("FAIL rwr_after: got lat=%0d r3=%h want 2 00a5", lat, rf[3]);
        end
    endtask

    initial begin
        res       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_dst   = 2'd0;
        cmd_srca  = 2'd0;
        cmd_srcb  = 2'd0;
        cmd_imm   = 16'h0;
        pl_en     = 1'b0;
        pl_idx    = 2'd0;
        pl_val    = 16'h0;
        @(negedge ck);
        test_reset();
        test_ldi();
        test_add_carry();
        test_sub();
        test_alias_mov();
        test_back_to_back();
        test_reset_in_wr();
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

endmodule
`default_nettype wire
